// File: rtl/lsu_port_arbiter.sv
// lsu_port_arbiter: shares the single LSU port between m0 (MEM stage) and m1 (boot/debug master).
// Optional build macro ARB_PERF_CNT_EN adds a saturating conflict counter output (conflict_cnt_o).
module lsu_port_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic              m0_lock_i,
    input  logic [31:0]       m0_addr_i,
    input  logic [3:0]        m0_op_i,
    input  logic [31:0]       m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [31:0]       m0_rdata_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic              m1_lock_i,
    input  logic [31:0]       m1_addr_i,
    input  logic [3:0]        m1_op_i,
    input  logic [31:0]       m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [31:0]       m1_rdata_o,
    output logic [31:0]       lsu_addr_o,
    output logic [3:0]        lsu_ld_op_o,
    output logic [31:0]       lsu_st_data_o,
    output logic              lsu_st_en_o,
    input  logic [31:0]       lsu_ld_data_i
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  conflict_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam int            BW         = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST);
    localparam bit            LOCK_EN    = (MAX_BURST > 1);

    if (MAX_BURST < 1 || CNT_W < 1) begin : gen_bad_cfg
        $error("lsu_port_arbiter: MAX_BURST and CNT_W must be >= 1");
    end

    state_t        state_reg, state_next;
    logic [BW-1:0] cnt_reg, cnt_next, cnt_inc;
    logic          rr_reg, rr_next;     // 0 favours m0, 1 favours m1

    logic [1:0]    req, we, lock;
    logic [1:0]    gnt, idle_gnt;
    logic [1:0]    rvalid;
    logic          owner_hold;
    logic          win;
    logic [31:0]   addr  [2];
    logic [31:0]   wdata [2];
    logic [3:0]    op    [2];
    logic [31:0]   rdata [2];

    assign req      = {m1_req_i, m0_req_i};
    assign we       = {m1_we_i, m0_we_i};
    assign lock     = {m1_lock_i, m0_lock_i};
    assign addr[0]  = m0_addr_i;
    assign addr[1]  = m1_addr_i;
    assign wdata[0] = m0_wdata_i;
    assign wdata[1] = m1_wdata_i;
    assign op[0]    = m0_op_i;
    assign op[1]    = m1_op_i;

    // Round-robin pick used whenever nobody holds the port
    always_comb begin
        idle_gnt = req;
        if (req == 2'b11) begin
            idle_gnt = rr_reg ? 2'b10 : 2'b01;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            rr_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rr_reg    <= rr_next;
        end
    end

    // FSM output logic: grant decision, gated off while reset is asserted
    always_comb begin
        owner_hold = 1'b0;
        gnt        = idle_gnt;
        case (state_reg)
            OWN0: begin
                if (req[0]) begin
                    owner_hold = 1'b1;
                    gnt        = 2'b01;
                end
            end
            OWN1: begin
                if (req[1]) begin
                    owner_hold = 1'b1;
                    gnt        = 2'b10;
                end
            end
            default: ;
        endcase
        if (!rst_ni) begin
            gnt = 2'b00;
        end
    end

    assign win     = gnt[1];
    assign cnt_inc = cnt_reg + BW'(1);

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rr_next    = rr_reg;
        if (owner_hold) begin
            cnt_next = cnt_inc;
            if (!lock[win] || cnt_inc >= BURST_LAST) begin
                state_next = IDLE;
                cnt_next   = '0;
                rr_next    = ~win;
            end
        end else begin
            // Owner absent or no owner: the cycle is arbitrated as IDLE
            state_next = IDLE;
            cnt_next   = '0;
            if (gnt != 2'b00) begin
                if (req == 2'b11) begin
                    rr_next = ~win;
                end
                if (LOCK_EN && lock[win]) begin
                    state_next = win ? OWN1 : OWN0;
                    cnt_next   = BW'(1);
                end
            end
        end
    end

    assign m0_gnt_o      = gnt[0];
    assign m1_gnt_o      = gnt[1];
    assign lsu_addr_o    = (|gnt) ? addr[win]  : '0;
    assign lsu_ld_op_o   = (|gnt) ? op[win]    : '0;
    assign lsu_st_data_o = (|gnt) ? wdata[win] : '0;
    assign lsu_st_en_o   = |(gnt & we);

    // One response slot per master; stores return zero data
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : gen_rsp
        logic        rvalid_reg;
        logic [31:0] rdata_reg;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rvalid_reg <= 1'b0;
                rdata_reg  <= '0;
            end else begin
                rvalid_reg <= gnt[gi];
                rdata_reg  <= (gnt[gi] && !we[gi]) ? lsu_ld_data_i : '0;
            end
        end

        assign rvalid[gi] = rvalid_reg;
        assign rdata[gi]  = rdata_reg;
    end

    assign m0_rvalid_o = rvalid[0];
    assign m1_rvalid_o = rvalid[1];
    assign m0_rdata_o  = rdata[0];
    assign m1_rdata_o  = rdata[1];

`ifdef ARB_PERF_CNT_EN
    logic [CNT_W-1:0] conflict_cnt_reg;
    logic             denied;

    assign denied = |(req & ~gnt);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conflict_cnt_reg <= '0;
        end else if (denied && !(&conflict_cnt_reg)) begin
            conflict_cnt_reg <= conflict_cnt_reg + CNT_W'(1);
        end
    end

    assign conflict_cnt_o = conflict_cnt_reg;
`endif

endmodule

// File: tb/tb_lsu_port_arbiter.sv
// Scoreboard bench for lsu_port_arbiter: directed scenarios then randomized traffic
// against a behavioural arbitration model; a negedge monitor checks every response.
module tb_lsu_port_arbiter;

    localparam int MB = 4;
    localparam int CW = 6;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        m0_req_i = 0, m0_we_i = 0, m0_lock_i = 0;
    logic [31:0] m0_addr_i = 0, m0_wdata_i = 0;
    logic [3:0]  m0_op_i = 0;
    logic        m1_req_i = 0, m1_we_i = 0, m1_lock_i = 0;
    logic [31:0] m1_addr_i = 0, m1_wdata_i = 0;
    logic [3:0]  m1_op_i = 0;
    logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic [31:0] lsu_addr_o, lsu_st_data_o;
    logic [3:0]  lsu_ld_op_o;
    logic        lsu_st_en_o;
    logic [31:0] lsu_ld_data_i = 0;
`ifdef ARB_PERF_CNT_EN
    logic [CW-1:0] conflict_cnt_o;
`endif

    lsu_port_arbiter #(.MAX_BURST(MB), .CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_lock_i(m0_lock_i),
        .m0_addr_i(m0_addr_i), .m0_op_i(m0_op_i), .m0_wdata_i(m0_wdata_i),
        .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_lock_i(m1_lock_i),
        .m1_addr_i(m1_addr_i), .m1_op_i(m1_op_i), .m1_wdata_i(m1_wdata_i),
        .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .lsu_addr_o(lsu_addr_o), .lsu_ld_op_o(lsu_ld_op_o),
        .lsu_st_data_o(lsu_st_data_o), .lsu_st_en_o(lsu_st_en_o),
        .lsu_ld_data_i(lsu_ld_data_i)
`ifdef ARB_PERF_CNT_EN
        , .conflict_cnt_o(conflict_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;
    exp_t q[2][$];

    // Behavioural model state
    int          mdl_owner = -1;
    int          mdl_run   = 0;
    int          mdl_fav   = 0;
    longint      conf_mdl  = 0;
    int          streak    = 0;
    int          streak_w  = -1;

    // Stimulus for the next cycle
    logic [1:0]  s_req = 0, s_we = 0, s_lock = 0;
    logic [31:0] s_addr [2];
    logic [3:0]  s_op   [2];
    logic [31:0] s_wdata[2];
    logic [31:0] s_ld = 0;
    logic [1:0]  last_dg = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void flush_model();
        q[0].delete();
        q[1].delete();
        mdl_owner = -1;
        mdl_run   = 0;
        mdl_fav   = 0;
        conf_mdl  = 0;
        streak    = 0;
        streak_w  = -1;
    endfunction

    // Arbitration rules: held ownership first, otherwise round robin on contention
    function automatic logic [1:0] model_step(input logic [1:0] rq, input logic [1:0] lk);
        int w = -1;
        logic [1:0] g = 2'b00;
        if (mdl_owner >= 0 && rq[mdl_owner]) begin
            w = mdl_owner;
            mdl_run++;
            if (!lk[w] || mdl_run >= MB) begin
                mdl_owner = -1;
                mdl_run   = 0;
                mdl_fav   = 1 - w;
            end
        end else begin
            mdl_owner = -1;
            mdl_run   = 0;
            if (rq == 2'b11) begin
                w       = mdl_fav;
                mdl_fav = 1 - w;
            end else if (rq[0]) begin
                w = 0;
            end else if (rq[1]) begin
                w = 1;
            end
            if (w >= 0 && lk[w] && MB > 1) begin
                mdl_owner = w;
                mdl_run   = 1;
            end
        end
        if (w >= 0) g[w] = 1'b1;
        return g;
    endfunction

    task automatic drive_cycle(output logic [1:0] g);
        logic [1:0]  dg;
        logic [31:0] ea, ed;
        logic [3:0]  eo;
        logic        es;
        int          w;
        @(posedge clk_i);
        #1;
        m0_req_i = s_req[0]; m0_we_i = s_we[0]; m0_lock_i = s_lock[0];
        m0_addr_i = s_addr[0]; m0_op_i = s_op[0]; m0_wdata_i = s_wdata[0];
        m1_req_i = s_req[1]; m1_we_i = s_we[1]; m1_lock_i = s_lock[1];
        m1_addr_i = s_addr[1]; m1_op_i = s_op[1]; m1_wdata_i = s_wdata[1];
        lsu_ld_data_i = s_ld;
        @(negedge clk_i);
`ifdef ARB_PERF_CNT_EN
        check("conflict_cnt", 32'(conflict_cnt_o), 32'(conf_mdl));
`endif
        g  = model_step(s_req, s_lock);
        dg = {m1_gnt_o, m0_gnt_o};
        last_dg = dg;
        check("gnt", 32'(dg), 32'(g));
        ea = 0; ed = 0; eo = 0; es = 0;
        if (g != 2'b00) begin
            w  = int'(g[1]);
            ea = s_addr[w]; eo = s_op[w]; ed = s_wdata[w]; es = s_we[w];
        end
        check("lsu_addr", lsu_addr_o, ea);
        check("lsu_ld_op", 32'(lsu_ld_op_o), 32'(eo));
        check("lsu_st_data", lsu_st_data_o, ed);
        check("lsu_st_en", 32'(lsu_st_en_o), 32'(es));
        for (int m = 0; m < 2; m++) begin
            if (g[m]) q[m].push_back('{due: cyc + 1, data: (s_we[m] ? 32'h0 : s_ld)});
        end
        if (dg != 2'b00) begin
            w = int'(dg[1]);
            if (s_req[1 - w]) begin
                if (w == streak_w) streak++;
                else begin
                    streak_w = w;
                    streak   = 1;
                end
                vectors++;
                if (streak > MB) begin
                    miscompares++;
                    $display("FAIL burst_cap: got %0d consecutive grants to m%0d, expected at most %0d", streak, w, MB);
                end
            end else begin
                streak_w = w;
                streak   = 0;
            end
        end
        if ((s_req & ~g) != 2'b00 && conf_mdl < (64'd1 << CW) - 1) conf_mdl++;
        $display("cyc %0d req %b lock %b we %b gnt %b addr %h st_en %b", cyc, s_req, s_lock, s_we, dg, lsu_addr_o, lsu_st_en_o);
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        m0_req_i = 1; m1_req_i = 1; m0_we_i = 1; m1_we_i = 1;
        flush_model();
        @(negedge clk_i);
        check("rst_gnt", 32'({m1_gnt_o, m0_gnt_o}), 32'h0);
        check("rst_st_en", 32'(lsu_st_en_o), 32'h0);
        check("rst_addr", lsu_addr_o, 32'h0);
`ifdef ARB_PERF_CNT_EN
        check("rst_conflict_cnt", 32'(conflict_cnt_o), 32'h0);
`endif
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        m0_req_i = 0; m1_req_i = 0; m0_we_i = 0; m1_we_i = 0;
    endtask

    // Response monitor: pops the scoreboard whenever a response is due
    always @(negedge clk_i) begin
        logic        rv, ev;
        logic [31:0] rd;
        for (int m = 0; m < 2; m++) begin
            rv = (m == 0) ? m0_rvalid_o : m1_rvalid_o;
            rd = (m == 0) ? m0_rdata_o  : m1_rdata_o;
            ev = (q[m].size() > 0) && (q[m][0].due == cyc);
            check($sformatf("m%0d_rvalid", m), 32'(rv), 32'(ev));
            if (ev) begin
                check($sformatf("m%0d_rdata", m), rd, q[m][0].data);
                void'(q[m].pop_front());
            end
        end
    end

    initial begin
        logic [1:0] g;
        logic [1:0] pend;
        logic [1:0] t2_exp[4];
        logic [1:0] t3_exp[6];
        logic [3:0] ops[5];
        int         m1_left, i;

        t2_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
        t3_exp = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
        ops    = '{4'b0001, 4'b0011, 4'b0111, 4'b1001, 4'b1011};
        for (int m = 0; m < 2; m++) begin
            s_addr[m] = 0; s_op[m] = 0; s_wdata[m] = 0;
        end

        // T1: single load from m0
        do_reset();
        s_req = 2'b01; s_we = 2'b00; s_lock = 2'b00;
        s_addr[0] = 32'h10; s_op[0] = 4'b0111; s_ld = 32'hDEADBEEF;
        drive_cycle(g);
        check("t1_gnt", 32'(last_dg), 32'h1);
        s_req = 2'b00; s_ld = 32'h0;
        drive_cycle(g);
        check("t1_rdata", m0_rdata_o, 32'hDEADBEEF);
        check("t1_m1_rdata", m1_rdata_o, 32'h0);

        // T2: plain contention alternates
        do_reset();
        s_req = 2'b11; s_we = 2'b00; s_lock = 2'b00;
        s_addr[0] = 32'h100; s_addr[1] = 32'h200;
        for (int k = 0; k < 4; k++) begin
            s_ld = $urandom;
            drive_cycle(g);
            check($sformatf("t2_gnt%0d", k), 32'(last_dg), 32'(t2_exp[k]));
        end
        s_req = 2'b00;
        drive_cycle(g);

        // T3: m1 locked store burst capped while m0 waits
        do_reset();
        s_we = 2'b10; s_lock = 2'b10;
        s_addr[1] = 32'h880; s_wdata[1] = 32'h12345678; s_op[1] = 4'b0111;
        s_addr[0] = 32'h40;  s_op[0] = 4'b0011;
        m1_left = 6;
        i = 0;
        while (m1_left > 0 && i < 20) begin
            s_req = {1'b1, (i > 0)};
            s_ld  = $urandom;
            drive_cycle(g);
            if (i < 6) check($sformatf("t3_gnt%0d", i), 32'(last_dg), 32'(t3_exp[i]));
            if (g[1]) m1_left--;
            i++;
        end
        check("t3_done", 32'(m1_left), 32'h0);

        // T4: owner drops request, other master gets the cycle
        do_reset();
        s_we = 2'b00; s_lock = 2'b01; s_req = 2'b01;
        drive_cycle(g);
        s_lock = 2'b00; s_req = 2'b10;
        drive_cycle(g);
        check("t4_gnt", 32'(last_dg), 32'h2);

        // T5: reset asserted during an m0 store grant
        @(posedge clk_i);
        #1;
        m0_req_i = 1; m0_we_i = 1; m0_lock_i = 0; m0_addr_i = 32'h880;
        m0_wdata_i = 32'h90000000; m0_op_i = 4'b0111; m1_req_i = 0;
        #2;
        rst_ni = 1'b0;
        flush_model();
        @(negedge clk_i);
        check("t5_gnt", 32'({m1_gnt_o, m0_gnt_o}), 32'h0);
        check("t5_st_en", 32'(lsu_st_en_o), 32'h0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        m0_req_i = 0;
        s_req = 2'b11; s_lock = 2'b00; s_we = 2'b00;
        drive_cycle(g);
        check("t5_ptr", 32'(last_dg), 32'h1);

        // Randomized traffic; requests stay stable until granted
        pend = 2'b00;
        repeat (3000) begin
            for (int m = 0; m < 2; m++) begin
                if (!pend[m] && ($urandom % 10) < 6) begin
                    pend[m]    = 1'b1;
                    s_we[m]    = 1'($urandom % 2);
                    s_lock[m]  = (($urandom % 3) != 0);
                    s_addr[m]  = $urandom;
                    s_op[m]    = ops[$urandom % 5];
                    s_wdata[m] = $urandom;
                end
            end
            s_req = pend;
            s_ld  = $urandom;
            drive_cycle(g);
            pend = pend & ~g;
        end
        s_req = 2'b00;
        repeat (3) drive_cycle(g);
        check("drain_m0", 32'(q[0].size()), 32'h0);
        check("drain_m1", 32'(q[1].size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
